// File: rtl/multicycle_ctrl_if.sv
// Memory-port handshake between the multicycle control FSM and the
// unified instruction/data memory.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic adr_src;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output adr_src,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  adr_src,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Control FSM for the shared multicycle RISC-V datapath: sequences
// fetch/decode/execute/memory/writeback and arbitrates the memory port.
module multicycle_ctrl (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        op,
    input  logic              zero,
    multicycle_ctrl_if.master mem,
    output logic              pc_we,
    output logic              ir_we,
    output logic              reg_we,
    output logic [1:0]        alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        alu_op,
    output logic [1:0]        result_src,
    output logic [2:0]        imm_src,
    output logic              retire,
    output logic              illegal
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LW  = 7'b0000011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EXEC_R,
        S_EXEC_I,
        S_LUI,
        S_ALU_WB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_we       = 1'b0;
        ir_we       = 1'b0;
        reg_we      = 1'b0;
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        mem.adr_src = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        result_src  = 2'b00;
        imm_src     = IMM_I;
        retire      = 1'b0;
        illegal     = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                mem.mem_req = 1'b1;
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
                ir_we       = mem.mem_ready;
                pc_we       = mem.mem_ready;
                if (mem.mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                if (op == OP_B) begin
                    imm_src = IMM_B;
                end else if (op == OP_JAL) begin
                    imm_src = IMM_J;
                end
                if (op == OP_LW || op == OP_SW) begin
                    state_d = S_MEM_ADDR;
                end else if (op == OP_R) begin
                    state_d = S_EXEC_R;
                end else if (op == OP_I) begin
                    state_d = S_EXEC_I;
                end else if (op == OP_LUI) begin
                    state_d = S_LUI;
                end else if (op == OP_B) begin
                    state_d = S_BRANCH;
                end else if (op == OP_JAL) begin
                    state_d = S_JAL;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (op == OP_SW) ? IMM_S : IMM_I;
                state_d   = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem.adr_src = 1'b1;
                mem.mem_req = 1'b1;
                if (mem.mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                result_src = 2'b01;
                reg_we     = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem.adr_src = 1'b1;
                mem.mem_req = 1'b1;
                mem.mem_we  = 1'b1;
                retire      = mem.mem_ready;
                if (mem.mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALU_WB;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                imm_src   = IMM_U;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_we  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_we     = zero;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                // PC <- ALUOut (target), ALUOut <- OldPC + 4 (link)
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_we     = 1'b1;
                state_d   = S_ALU_WB;
            end
            default: begin
                illegal = 1'b1;
                state_d = S_TRAP;
            end
        endcase

        // Reset kills any pending request and write in the same cycle
        if (reset) begin
            pc_we       = 1'b0;
            ir_we       = 1'b0;
            reg_we      = 1'b0;
            mem.mem_req = 1'b0;
            mem.mem_we  = 1'b0;
            retire      = 1'b0;
            illegal     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized check of multicycle_ctrl against a per-instruction
// step-sequence model with cycle-count (latency) checks.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       zero;
    logic       pc_we, ir_we, reg_we, retire, illegal;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0] imm_src;

    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .mem        (bus),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .reg_we     (reg_we),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .imm_src    (imm_src),
        .retire     (retire),
        .illegal    (illegal)
    );

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       adr_src;
        logic       mem_req;
        logic       mem_we;
        logic       reg_we;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] aop;
        logic [1:0] rs;
        logic [2:0] imm;
        logic       retire;
        logic       illegal;
    } out_t;

    out_t dut_o;
    assign dut_o = {pc_we, ir_we, bus.adr_src, bus.mem_req, bus.mem_we,
                    reg_we, alu_src_a, alu_src_b, alu_op, result_src,
                    imm_src, retire, illegal};

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // Phases an instruction walks through
    localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5;
    localparam int ER = 6, EI = 7, LU = 8, AWB = 9, BR = 10, JL = 11, TR = 12;

    int n_cmp = 0;
    int n_err = 0;
    int seq[$];
    int idx;
    int cyc;
    int waits;
    bit need_new = 1'b1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic out_t exp_out(input int s, input logic [6:0] o,
                                     input logic rdy, input logic z);
        out_t e;
        e = '0;
        case (s)
            F: begin
                e.pc_we = rdy; e.ir_we = rdy; e.mem_req = 1'b1;
                e.b = 2'b10; e.rs = 2'b10;
            end
            D: begin
                e.a = 2'b01; e.b = 2'b01;
                e.imm = (o == OP_B) ? 3'b010 : (o == OP_JAL) ? 3'b100 : 3'b000;
            end
            MA: begin
                e.a = 2'b10; e.b = 2'b01;
                e.imm = (o == OP_SW) ? 3'b001 : 3'b000;
            end
            MR:  begin e.adr_src = 1'b1; e.mem_req = 1'b1; end
            MWB: begin e.rs = 2'b01; e.reg_we = 1'b1; e.retire = 1'b1; end
            MW: begin
                e.adr_src = 1'b1; e.mem_req = 1'b1; e.mem_we = 1'b1;
                e.retire = rdy;
            end
            ER:  begin e.a = 2'b10; e.aop = 2'b10; end
            EI:  begin e.a = 2'b10; e.b = 2'b01; e.aop = 2'b10; end
            LU:  begin e.a = 2'b11; e.b = 2'b01; e.imm = 3'b011; end
            AWB: begin e.reg_we = 1'b1; e.retire = 1'b1; end
            BR: begin
                e.a = 2'b10; e.aop = 2'b01; e.pc_we = z; e.retire = 1'b1;
            end
            JL:  begin e.a = 2'b01; e.b = 2'b10; e.pc_we = 1'b1; end
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    function automatic bit is_mem(input int s);
        return s == F || s == MR || s == MW;
    endfunction

    task automatic start(input logic [6:0] o);
        op = o;
        seq.delete();
        case (o)
            OP_R:    seq = '{F, D, ER, AWB};
            OP_I:    seq = '{F, D, EI, AWB};
            OP_LUI:  seq = '{F, D, LU, AWB};
            OP_B:    seq = '{F, D, BR};
            OP_SW:   seq = '{F, D, MA, MW};
            OP_LW:   seq = '{F, D, MA, MR, MWB};
            OP_JAL:  seq = '{F, D, JL, AWB};
            default: seq = '{F, D, TR};
        endcase
        idx = 0; cyc = 0; waits = 0; need_new = 1'b0;
    endtask

    task automatic step_cycle(input logic rdy, input logic z, input logic rst);
        int s;
        bus.mem_ready = rdy;
        zero = z;
        reset = rst;
        s = (seq.size() > 0) ? seq[idx] : F;
        @(negedge clk);
        if (rst) begin
            check("rst_enables",
                  {25'd0, pc_we, ir_we, reg_we, bus.mem_req, bus.mem_we,
                   retire, illegal}, 32'd0);
        end else begin
            check($sformatf("out_phase%0d_op%b", s, op), dut_o,
                  exp_out(s, op, rdy, z));
            cyc++;
            if (is_mem(s) && !rdy) waits++;
            if (retire) check("latency", cyc, seq.size() + waits);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            need_new = 1'b1;
            idx = 0;
        end else if (s == TR || (is_mem(s) && !rdy)) begin
            idx = idx;
        end else begin
            idx++;
            if (idx == seq.size()) need_new = 1'b1;
        end
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input logic [6:0] o, input int fw, input int mw,
                             input logic z);
        int nf = 0, nm = 0, guard = 0, s;
        logic r;
        start(o);
        while (!need_new && guard < 200) begin
            s = seq[idx];
            if (s == F) begin
                r = (nf >= fw); nf++;
            end else if (s == MR || s == MW) begin
                r = (nm >= mw); nm++;
            end else begin
                r = rnd_bit();
            end
            step_cycle(r, z, 1'b0);
            guard++;
        end
        if (guard >= 200) check("timeout", 32'd1, 32'd0);
    endtask

    initial begin
        logic [6:0] ops [7];
        logic [6:0] o;
        int nm;
        ops = '{OP_R, OP_I, OP_B, OP_LUI, OP_SW, OP_JAL, OP_LW};
        reset = 1'b1; op = 7'd0; zero = 1'b0; bus.mem_ready = 1'b0;

        step_cycle(1'b1, 1'b0, 1'b1);
        step_cycle(1'b0, 1'b0, 1'b1);

        run_instr(OP_R,   0, 0, 1'b0);
        run_instr(OP_LW,  2, 3, 1'b0);
        run_instr(OP_SW,  0, 0, 1'b1);
        run_instr(OP_B,   0, 0, 1'b1);
        run_instr(OP_B,   0, 0, 1'b0);
        run_instr(OP_JAL, 0, 0, 1'b0);
        run_instr(OP_LUI, 0, 0, 1'b0);
        run_instr(OP_I,   1, 0, 1'b1);
        run_instr(OP_SW,  1, 2, 1'b0);

        // Illegal opcode: sit in TRAP, then recover through reset
        start(OP_BAD);
        while (seq[idx] != TR) step_cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step_cycle(rnd_bit(), rnd_bit(), 1'b0);
        step_cycle(1'b0, 1'b0, 1'b1);
        run_instr(OP_R, 0, 0, 1'b0);

        // Reset during a stalled load read
        start(OP_LW);
        nm = 0;
        for (int g = 0; g < 50 && !need_new; g++) begin
            if (seq[idx] == MR && nm == 1) begin
                step_cycle(1'b0, 1'b0, 1'b1);
            end else if (seq[idx] == MR) begin
                nm++;
                step_cycle(1'b0, 1'b0, 1'b0);
            end else begin
                step_cycle(1'b1, 1'b0, 1'b0);
            end
        end
        run_instr(OP_LW, 0, 0, 1'b0);

        for (int k = 0; k < 400; k++) begin
            o = ops[$urandom_range(0, 6)];
            run_instr(o, $urandom_range(0, 3), $urandom_range(0, 3), rnd_bit());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
